seq_radix4_mult_ctrl: RTL and testbench
=======================================

Name: seq_radix4_mult_ctrl

Overview:
Iterative 32x32 unsigned multiplier controller that feeds and consumes the 37+35-bit unsigned adder stage directly downstream of it.
- Each iteration drives a 37-bit running upper accumulator and a 35-bit partial product into the adder.
- It takes the 38-bit sum back, shifts it right by 2 and retires 2 product bits.
- 16 iterations produce a 64-bit product with a valid/ready handshake on both sides.

Parameters:
OP_W, 32, operand width; must be 32, because the adder widths 37/35/38 are sized for it; ITER = OP_W/2 = 16 is a localparam.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
in_mcand  input  32  multiplicand
in_mplr  input  32  multiplier
add_a  output  37  adder operand A = running upper accumulator
add_b  output  35  adder operand B = partial product, zero-extended
add_sum  input  38  adder result (combinational, same cycle)
out_valid  output  1  product valid (high only in DONE)
out_ready  input  1  consumer accepts product
out_product  output  64  registered product
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi, lo, mcand, mplr, cnt and out_product all cleared.
  - in_ready=1 once rst_n=1; out_valid=0, busy=0, add_a=0, add_b=0.
  - Reset mid-operation aborts the operation with no output.
- Registers: hi[36:0], lo[31:0], mcand[31:0], mplr[31:0], cnt[4:0].
- IDLE: on in_valid&in_ready, capture mcand/mplr, clear hi, lo and cnt, go to CALC.
- CALC, one iteration per cycle:
  - digit = mplr[1:0].
  - add_a = hi; add_b = {1'b0, mcand*digit}. The product is at most 34 bits, so no overflow is possible.
  - Next hi = {1'b0, add_sum[37:2]}; next lo = {add_sum[1:0], lo[31:2]}; mplr >>= 2; cnt += 1.
  - When cnt==15 (last iteration): out_product <= {next hi[31:0], next lo}; go to DONE.
- Outside CALC, add_a and add_b are driven to 0.
- DONE: out_valid=1. out_product and out_valid hold until out_ready=1, then go to IDLE. in_valid is ignored in DONE (no same-cycle re-accept).
- Latency with the macro off: accepting edge E0, 16 CALC edges; out_valid high after E16, i.e. 16 edges, fixed.
- Bits 36:32 of hi are always 0 at completion.
- Multiplier 0 and multiplicand 0 follow the normal path; the product is 0.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined:
  - At the start of any CALC cycle with mplr==0 and cnt<16, no add is performed (add_a/add_b=0) and the state goes to FINISH. Let rem = 16 - cnt.
  - FINISH (1 cycle): out_product <= ({hi[31:0], lo} >> (2*rem))[63:0], then go to DONE.
  - The last-iteration rule is unchanged.
  - Latency = (digits processed) + 2 edges, where digits processed is the number of iterations until mplr becomes 0.
- Undefined: the FINISH state does not exist; latency is always 16.

Test Plan:
1. Reset: rst_n=0 at the 5th CALC cycle of 0xFFFF x 0x10001, then released -> out_valid=0, in_ready=1, out_product=0; a new op 2x3 then yields 0x6.
2. mcand=0xFFFFFFFF, mplr=0xFFFFFFFF (macro off) -> out_product=0xFFFFFFFE00000001, out_valid high exactly 16 edges after accept, add_b=0x2FFFFFFFD every CALC cycle.
3. mcand=0x0000FFFF, mplr=0x00010001 -> 0x00000000FFFFFFFF; mcand=0x80000000, mplr=0x3 -> 0x0000000180000000.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_product and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
5. EARLY_TERM_EN defined, mcand=7, mplr=0x3 -> out_product=0x15 after 3 edges; same op with the macro undefined -> 0x15 after 16 edges.
6. EARLY_TERM_EN defined, mplr=0, mcand=0xDEADBEEF -> out_product=0 after 2 edges; add_a=add_b=0 throughout.

Source files
------------

// File: rtl/seq_radix4_mult_ctrl_if.sv
// Handshake and adder-bus bundle for seq_radix4_mult_ctrl.
// The master side is the multiplier controller; the slave side is the operand source, product consumer and adder.
interface seq_radix4_mult_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mcand;
    logic [31:0] in_mplr;
    logic [36:0] add_a;
    logic [34:0] add_b;
    logic [37:0] add_sum;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic        busy;

    modport master (
        input  in_valid, in_mcand, in_mplr, add_sum, out_ready,
        output in_ready, add_a, add_b, out_valid, out_product, busy
    );

    modport slave (
        output in_valid, in_mcand, in_mplr, add_sum, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_product, busy
    );
endinterface

// File: rtl/seq_radix4_mult_ctrl.sv
// Radix-4 iterative 32x32 unsigned multiplier controller driving an external 37+35-bit adder.
// Optional macro EARLY_TERM_EN: finish early once the remaining multiplier digits are all zero.
module seq_radix4_mult_ctrl #(
    parameter int OP_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_radix4_mult_ctrl_if.master bus
);
    localparam int ITER = OP_W / 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
`ifdef EARLY_TERM_EN
    localparam logic [1:0] FINISH = 2'd3;
`endif

    logic [1:0]      state;
    logic [36:0]     hi;
    logic [OP_W-1:0] lo;
    logic [OP_W-1:0] mcand;
    logic [OP_W-1:0] mplr;
    logic [4:0]      cnt;

    logic [1:0]      digit;
    logic [33:0]     pp;
    logic [36:0]     next_hi;
    logic [OP_W-1:0] next_lo;
    logic            do_add;

    assign digit   = mplr[1:0];
    // mcand * digit fits in 34 bits, so the adder can never overflow 38 bits
    assign pp      = {2'b00, mcand} * {32'd0, digit};
    assign next_hi = {1'b0, bus.add_sum[37:2]};
    assign next_lo = {bus.add_sum[1:0], lo[OP_W-1:2]};

`ifdef EARLY_TERM_EN
    logic [4:0] rem;
    logic [5:0] sh;
    assign do_add = (state == CALC) && (mplr != '0);
    assign rem    = 5'(ITER) - cnt;
    assign sh     = {rem, 1'b0};
`else
    assign do_add = (state == CALC);
`endif

    always_comb begin
        bus.add_a = '0;
        bus.add_b = '0;
        if (do_add) begin
            bus.add_a = hi;
            bus.add_b = {1'b0, pp};
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hi              <= '0;
            lo              <= '0;
            mcand           <= '0;
            mplr            <= '0;
            cnt             <= '0;
            bus.out_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= bus.in_mcand;
                        mplr  <= bus.in_mplr;
                        hi    <= '0;
                        lo    <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
`ifdef EARLY_TERM_EN
                    if (mplr == '0) begin
                        state <= FINISH;
                    end else
`endif
                    begin
                        hi   <= next_hi;
                        lo   <= next_lo;
                        mplr <= mplr >> 2;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'(ITER - 1)) begin
                            bus.out_product <= {next_hi[OP_W-1:0], next_lo};
                            state           <= DONE;
                        end
                    end
                end
`ifdef EARLY_TERM_EN
                FINISH: begin
                    // realign the product: skipped digits never shifted into lo
                    bus.out_product <= {hi[OP_W-1:0], lo} >> sh;
                    state           <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_radix4_mult_ctrl.sv
// Self-checking bench for seq_radix4_mult_ctrl: directed and random operands against an arithmetic model,
// with the downstream adder modelled combinationally.
module tb_seq_radix4_mult_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    seq_radix4_mult_ctrl_if bus();

    seq_radix4_mult_ctrl #(.OP_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.add_sum = {1'b0, bus.add_a} + {3'b000, bus.add_b};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // number of radix-4 digits up to and including the most significant nonzero one
    function automatic int digits_of(input logic [31:0] b);
        int n = 0;
        logic [31:0] t = b;
        while (t != 0) begin
            t = t >> 2;
            n++;
        end
        return n;
    endfunction

    // Accepts one op and walks it to DONE, leaving out_ready low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat, nadd;
        logic [63:0] exp_a, exp_b, mask;
`ifdef EARLY_TERM_EN
        nadd = digits_of(b);
        lat  = (nadd < 16) ? nadd + 2 : 16;
`else
        nadd = 16;
        lat  = 16;
`endif
        bus.out_ready = 1'b0;
        bus.in_mcand  = a;
        bus.in_mplr   = b;
        bus.in_valid  = 1'b1;
        chk({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mcand = $urandom;
        bus.in_mplr  = $urandom;
        for (int k = 0; k < lat; k++) begin
            chk({tag, ".out_valid_early"}, 64'(bus.out_valid), 64'd0);
            chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
            if (k < nadd) begin
                mask  = (64'd1 << (2 * k)) - 64'd1;
                exp_a = (64'(a) * (64'(b) & mask)) >> (2 * k);
                exp_b = 64'(a) * ((64'(b) >> (2 * k)) & 64'd3);
            end else begin
                exp_a = 64'd0;
                exp_b = 64'd0;
            end
            chk($sformatf("%s.add_a[%0d]", tag, k), 64'(bus.add_a), exp_a);
            chk($sformatf("%s.add_b[%0d]", tag, k), 64'(bus.add_b), exp_b);
            @(negedge clk);
        end
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".product"}, bus.out_product, 64'(a) * 64'(b));
        chk({tag, ".in_ready_done"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic release_op(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".out_valid_after"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
        chk({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra, rb;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mcand  = '0;
        bus.in_mplr   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.add_a", 64'(bus.add_a), 64'd0);
        chk("rst.add_b", 64'(bus.add_b), 64'd0);
        chk("rst.product", bus.out_product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // reset in the 5th CALC cycle aborts the op
        bus.in_mcand = 32'h0000FFFF;
        bus.in_mplr  = 32'h00010001;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort.busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort.busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort.product", bus.out_product, 64'd0);
        chk("abort.out_valid_post", 64'(bus.out_valid), 64'd0);
        run_op(32'd2, 32'd3, "after_abort");
        chk("after_abort.exact", bus.out_product, 64'h6);
        release_op("after_abort");

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "max");
        chk("max.exact", bus.out_product, 64'hFFFFFFFE00000001);
        release_op("max");

        run_op(32'h0000FFFF, 32'h00010001, "mix");
        chk("mix.exact", bus.out_product, 64'h00000000FFFFFFFF);
        release_op("mix");

        run_op(32'h80000000, 32'h3, "msb");
        chk("msb.exact", bus.out_product, 64'h0000000180000000);
        release_op("msb");

        run_op(32'd7, 32'h3, "small");
        chk("small.exact", bus.out_product, 64'h15);
        release_op("small");

        run_op(32'hDEADBEEF, 32'h0, "zero_mplr");
        chk("zero_mplr.exact", bus.out_product, 64'h0);
        release_op("zero_mplr");

        run_op(32'h0, 32'hC0000001, "zero_mcand");
        release_op("zero_mcand");

        // backpressure: product held, new operands ignored
        run_op(32'h12345678, 32'h9ABCDEF0, "bp");
        held = bus.out_product;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_mcand = $urandom;
            bus.in_mplr  = $urandom;
            @(negedge clk);
            chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp.product_hold", bus.out_product, held);
            chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
        end
        release_op("bp");

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, $sformatf("rand%0d", n));
            if (n % 3 == 0) begin
                bus.in_valid = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                chk("rand.out_valid_stall", 64'(bus.out_valid), 64'd1);
            end
            release_op($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
